// File: rtl/accel_pkg.sv
// Shared constants and state type for the accelerometer SPI sequencer.
// The burst length depends on ACCEL_TEMP_EN, which is consumed by accel_spi_sequencer.
package accel_pkg;
  localparam logic [7:0] CMD_WR         = 8'h0A;
  localparam logic [7:0] CMD_RD         = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL  = 8'h2D;
  localparam logic [7:0] REG_XDATA_L    = 8'h0E;
  localparam logic [7:0] REG_TEMP_L     = 8'h14;
  localparam logic [7:0] POWER_CTL_MEAS = 8'h02;

  typedef enum logic [2:0] {S_BOOT, S_CFG, S_GAP, S_IDLE, S_RD, S_UPDATE} state_t;

  // Data bytes in one burst: X/Y/Z only, or contiguous through TEMP_H.
  function automatic int data_bytes(input bit with_temp);
    return with_temp ? int'(REG_TEMP_L - REG_XDATA_L) + 2 : 6;
  endfunction
endpackage

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI byte shifter: each bit is a low then a high half-period of CLK_DIV clocks.
// done flags the clock edge of the final falling edge so the next byte can start back-to-back.
module spi_byte_engine #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rstbt,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);
  localparam int HW = $clog2(CLK_DIV);
  localparam logic [HW-1:0] HEND = HW'(CLK_DIV - 1);

  logic          active;
  logic          sclk_q;
  logic [HW-1:0] hcnt;
  logic [2:0]    bcnt;
  logic [7:0]    tsh;
  logic [7:0]    rsh;
  logic          half_end;

  assign half_end = active && (hcnt == HEND);
  assign done     = half_end && sclk_q && (bcnt == 3'd7);
  assign sclk     = sclk_q;
  assign mosi     = active & tsh[7];
  assign rx_byte  = rsh;

  always_ff @(posedge clk or negedge rstbt) begin
    if (!rstbt) begin
      active <= 1'b0;
      sclk_q <= 1'b0;
      hcnt   <= '0;
      bcnt   <= '0;
      tsh    <= '0;
      rsh    <= '0;
    end else if (!active || done) begin
      if (start) begin
        active <= 1'b1;
        tsh    <= tx_byte;
        bcnt   <= '0;
        hcnt   <= '0;
        sclk_q <= 1'b0;
      end else if (done) begin
        active <= 1'b0;
        sclk_q <= 1'b0;
        hcnt   <= '0;
      end
    end else if (half_end) begin
      hcnt   <= '0;
      sclk_q <= ~sclk_q;
      if (!sclk_q) rsh <= {rsh[6:0], miso};
      else begin
        tsh  <= {tsh[6:0], 1'b0};
        bcnt <= bcnt + 3'd1;
      end
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end
endmodule

// File: rtl/accel_spi_sequencer.sv
// ADXL362 sequencer: configure measurement mode, then periodically burst-read X/Y/Z.
// Define ACCEL_TEMP_EN to extend the burst with TEMP_L/TEMP_H and add the temp output.
module accel_spi_sequencer
  import accel_pkg::*;
#(
  parameter int CLK_DIV       = 50,
  parameter int SAMPLE_PERIOD = 1000000,
  parameter int CS_GAP        = 100
) (
  input  logic        clk,
  input  logic        rstbt,
  input  logic        en,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic [11:0] z,
`ifdef ACCEL_TEMP_EN
  output logic [11:0] temp,
`endif
  output logic        valid,
  output logic        cfg_done,
  output logic        busy
);
`ifdef ACCEL_TEMP_EN
  localparam bit TEMP_EN = 1'b1;
`else
  localparam bit TEMP_EN = 1'b0;
`endif
  localparam int NDATA = data_bytes(TEMP_EN);
  localparam int NSAMP = NDATA / 2;
  localparam logic [3:0] CFG_LAST = 4'd2;
  localparam logic [3:0] RD_LAST  = 4'(NDATA + 1);
  localparam int GMAX = (CS_GAP > 2 * CLK_DIV) ? CS_GAP : 2 * CLK_DIV;
  localparam int GW = $clog2(GMAX + 1);
  localparam logic [GW-1:0] GAP_END  = GW'(CS_GAP - 1);
  localparam logic [GW-1:0] TAIL_END = GW'(2 * CLK_DIV - 1);
  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [PW-1:0] PMAX = PW'(SAMPLE_PERIOD);

  state_t        state, nstate;
  logic [GW-1:0] gcnt;
  logic [PW-1:0] pcnt;
  logic [3:0]    bidx;
  logic          tail;
  logic          start, done, last_done;
  logic [7:0]    txb, rxb;
  logic [1:0]    sidx;
  logic [11:0]   samp [NSAMP];

  assign cs_n      = !(state == S_CFG || state == S_RD);
  assign busy      = !cs_n;
  assign last_done = done && (bidx == ((state == S_RD) ? RD_LAST : CFG_LAST));
  assign sidx      = 2'((bidx - 4'd2) >> 1);

  spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_eng (
    .clk     (clk),
    .rstbt   (rstbt),
    .start   (start),
    .tx_byte (txb),
    .rx_byte (rxb),
    .done    (done),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso)
  );

  // After the last byte cs_n is held for two half-periods, giving (16*bytes+2)*CLK_DIV low time.
  always_comb begin
    nstate = state;
    start  = 1'b0;
    txb    = 8'h00;
    case (state)
      S_BOOT: if (gcnt == GAP_END) begin
        nstate = S_CFG;
        start  = 1'b1;
        txb    = CMD_WR;
      end
      S_CFG: begin
        if (tail) begin
          if (gcnt == TAIL_END) nstate = S_GAP;
        end else if (done && !last_done) begin
          start = 1'b1;
          txb   = (bidx == 4'd0) ? REG_POWER_CTL : POWER_CTL_MEAS;
        end
      end
      S_GAP:  if (gcnt == GAP_END) nstate = S_IDLE;
      S_IDLE: if (en && pcnt == PMAX) begin
        nstate = S_RD;
        start  = 1'b1;
        txb    = CMD_RD;
      end
      S_RD: begin
        if (tail) begin
          if (gcnt == TAIL_END) nstate = S_UPDATE;
        end else if (done && !last_done) begin
          start = 1'b1;
          txb   = (bidx == 4'd0) ? REG_XDATA_L : 8'h00;
        end
      end
      S_UPDATE: nstate = S_GAP;
      default:  nstate = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rstbt) begin
    if (!rstbt) begin
      state    <= S_BOOT;
      gcnt     <= '0;
      pcnt     <= PMAX;
      bidx     <= '0;
      tail     <= 1'b0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
`ifdef ACCEL_TEMP_EN
      temp     <= '0;
`endif
      valid    <= 1'b0;
      cfg_done <= 1'b0;
      for (int i = 0; i < NSAMP; i++) samp[i] <= '0;
    end else begin
      state <= nstate;
      valid <= (state == S_UPDATE);
      if (state != nstate || last_done) gcnt <= '0;
      else                              gcnt <= gcnt + GW'(1);
      if (state != nstate) begin
        bidx <= '0;
        tail <= 1'b0;
      end else if (done) begin
        bidx <= bidx + 4'd1;
        if (last_done) tail <= 1'b1;
      end
      // Period counter restarts on each read entry and saturates so an idle read starts at once.
      if (state == S_IDLE && nstate == S_RD) pcnt <= PW'(1);
      else if (pcnt != PMAX)                 pcnt <= pcnt + PW'(1);
      if (state == S_CFG && nstate == S_GAP) cfg_done <= 1'b1;
      // Odd burst bytes are high bytes; only their low nibble carries sample bits.
      if (state == S_RD && done && bidx >= 4'd2) begin
        if (bidx[0]) samp[sidx][11:8] <= rxb[3:0];
        else         samp[sidx][7:0]  <= rxb;
      end
      if (state == S_UPDATE) begin
        x <= samp[0];
        y <= samp[1];
        z <= samp[2];
`ifdef ACCEL_TEMP_EN
        temp <= samp[3];
`endif
      end
    end
  end
endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Bench for accel_spi_sequencer: bit-level sensor model, transaction log and per-cycle output model.
module tb_accel_spi_sequencer;
  localparam int CD = 2, GAP = 10, PER = 600;
`ifdef ACCEL_TEMP_EN
  localparam int NDB = 8;
  localparam int RD_LEN = 324;
`else
  localparam int NDB = 6;
  localparam int RD_LEN = 260;
`endif
  localparam int NRD = NDB + 2;

  logic clk = 1'b0, rstbt = 1'b0, en = 1'b0, miso = 1'b0;
  logic sclk, mosi, cs_n, valid, cfg_done, busy;
  logic [11:0] x, y, z;
`ifdef ACCEL_TEMP_EN
  logic [11:0] temp;
`endif

  always #5 clk = ~clk;

  accel_spi_sequencer #(.CLK_DIV(CD), .SAMPLE_PERIOD(PER), .CS_GAP(GAP)) dut (
    .clk(clk), .rstbt(rstbt), .en(en), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .x(x), .y(y), .z(z),
`ifdef ACCEL_TEMP_EN
    .temp(temp),
`endif
    .valid(valid), .cfg_done(cfg_done), .busy(busy));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [7:0] regs [0:63];

  function automatic logic [11:0] s12(input int a);
    int hi;
    hi = regs[a + 1] % 16;
    return 12'(hi * 256 + regs[a]);
  endfunction

  // Sensor and output model state
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  int nbits = 0, fall_cyc = 0, nfall = 0, last_fall = 0, reads_done = 0, valid_seen = 0;
  int pend = -1, len = 0, a = 0;
  logic [7:0] cur = 8'h00;
  logic [7:0] tb[$];
  logic [23:0] done_b3[$];
  int done_len[$], rd_fall[$];
  logic [11:0] ex = 0, ey = 0, ez = 0, et = 0, px = 0, py = 0, pz = 0, pt = 0;
  logic exv = 1'b0, ecfg = 1'b0;

  always @(negedge clk) begin
    if (!rstbt) begin
      ex = 0; ey = 0; ez = 0; et = 0; exv = 0; ecfg = 0; pend = -1;
      prev_cs = 1; prev_sclk = 0; prev_mosi = 0; miso = 0;
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_valid", valid, 0);
      chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_z", z, 0);
      chk("rst_cfg_done", cfg_done, 0);
    end else begin
      if (prev_cs && !cs_n) begin
        nbits = 0; tb.delete(); fall_cyc = cyc; nfall++; last_fall = cyc;
      end else if (!prev_cs && cs_n) begin
        len = cyc - fall_cyc;
        done_b3.push_back(tb.size() >= 3 ? {tb[0], tb[1], tb[2]} : 24'h0);
        done_len.push_back(len);
        chk("cs_low_len", len, (16 * tb.size() + 2) * CD);
        if (tb.size() == 3 && tb[0] == 8'h0A && tb[1] == 8'h2D && tb[2] == 8'h02) ecfg = 1;
        if (tb.size() == NRD && tb[0] == 8'h0B) begin
          a = tb[1];
          px = s12(a); py = s12(a + 2); pz = s12(a + 4); pt = s12(a + 6);
          pend = cyc + 1; reads_done++; rd_fall.push_back(fall_cyc);
        end
      end
      if (!cs_n) begin
        if (!prev_sclk && sclk) begin
          cur = {cur[6:0], mosi}; nbits++;
          if (nbits % 8 == 0) tb.push_back(cur);
        end
        if (!prev_cs && sclk) chk("mosi_hold_hi", mosi, prev_mosi);
        if (prev_cs || (prev_sclk && !sclk)) begin
          if (nbits / 8 >= 2 && tb.size() >= 2 && tb[0] == 8'h0B)
            miso = regs[tb[1] + nbits / 8 - 2][7 - nbits % 8];
          else
            miso = 1'b0;
        end
      end
      if (cyc == pend) begin
        ex = px; ey = py; ez = pz; et = pt; exv = 1;
      end else exv = 0;
      chk("valid", valid, exv);
      chk("x", x, ex); chk("y", y, ez === ez ? ey : ey); chk("z", z, ez);
`ifdef ACCEL_TEMP_EN
      chk("temp", temp, et);
`endif
      chk("busy", busy, !cs_n);
      if (cs_n) chk("sclk_idle", sclk, 0);
      chk("cfg_done", cfg_done, ecfg);
      if (valid) valid_seen++;
      prev_cs = cs_n; prev_sclk = sclk; prev_mosi = mosi;
    end
  end

  task automatic set_pattern(input logic [7:0] p [8]);
    for (int i = 0; i < 8; i++) regs[14 + i] = p[i];
  endtask

  int rel, r0, n0, k, nd, nf;
  logic [7:0] pat1 [8] = '{8'h34, 8'hF1, 8'hFF, 8'h07, 8'h00, 8'hF8, 8'h10, 8'h02};
  logic [7:0] pat2 [8] = '{8'hFF, 8'h0F, 8'h01, 8'h00, 8'hAB, 8'hF5, 8'hCD, 8'h0E};

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = 8'h00;
    set_pattern(pat1);
    rstbt = 0; en = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mosi", mosi, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cs_n", cs_n, 1);

    // Configuration write after reset release
    @(posedge clk); #1; rstbt = 1; rel = cyc;
    for (int i = 0; i < 50 && nfall < 1; i++) @(negedge clk);
    chk("cfg_fall_cycle", last_fall, rel + GAP);
    for (int i = 0; i < 300 && done_b3.size() < 1; i++) @(negedge clk);
    chk("cfg_seen", done_b3.size(), 1);
    chk("cfg_bytes", done_b3[0], 24'h0A2D02);
    chk("cfg_len", done_len[0], 100);
    chk("cfg_done_set", cfg_done, 1);

    // First read, literal sample values
    for (int i = 0; i < 1000 && !valid; i++) @(negedge clk);
    chk("first_valid", valid, 1);
    chk("x_pat1", x, 12'h134); chk("y_pat1", y, 12'h7FF); chk("z_pat1", z, 12'h800);
`ifdef ACCEL_TEMP_EN
    chk("temp_pat1", temp, 12'h210);
`endif
    chk("rd_bytes", done_b3[done_b3.size() - 1], 24'h0B0E00);
    chk("rd_len", done_len[done_len.size() - 1], RD_LEN);
    set_pattern(pat2);

    // Periodic reads
    r0 = reads_done;
    for (int i = 0; i < 3000 && reads_done < r0 + 3; i++) @(negedge clk);
    chk("three_reads", reads_done, r0 + 3);
    repeat (2) @(negedge clk);
    for (int i = rd_fall.size() - 3; i < rd_fall.size(); i++)
      chk("period", rd_fall[i] - rd_fall[i - 1], PER);
    chk("valid_count", valid_seen, reads_done);
    chk("x_pat2", x, 12'hFFF); chk("y_pat2", y, 12'h001); chk("z_pat2", z, 12'h5AB);
`ifdef ACCEL_TEMP_EN
    chk("temp_pat2", temp, 12'hECD);
`endif

    // en low holds off reads; read starts the cycle after en returns
    @(posedge clk); #1; en = 0; n0 = nfall;
    repeat (2000) @(posedge clk);
    chk("no_reads_en_low", nfall, n0);
    #1; en = 1; k = cyc;
    for (int i = 0; i < 10 && nfall == n0; i++) @(negedge clk);
    chk("en_rise_fall", last_fall, k + 1);

    // Reset in the middle of byte 4 of a read
    nf = last_fall;
    for (int i = 0; i < 200 && cyc < nf + 100; i++) @(posedge clk);
    #1; rstbt = 0; nd = done_b3.size();
    #1;
    chk("midrst_cs_n", cs_n, 1); chk("midrst_sclk", sclk, 0);
    chk("midrst_x", x, 0); chk("midrst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1; rstbt = 1;
    for (int i = 0; i < 500 && done_b3.size() <= nd; i++) @(negedge clk);
    chk("reconfig_seen", done_b3.size(), nd + 1);
    chk("reconfig_first", done_b3[nd], 24'h0A2D02);
    for (int i = 0; i < 1000 && !valid; i++) @(negedge clk);
    chk("post_rst_valid", valid, 1);
    chk("x_post", x, 12'hFFF); chk("z_post", z, 12'h5AB);
    repeat (2) @(negedge clk);
    chk("valid_count_end", valid_seen, reads_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
